// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: bundles the fetch port, the load/store port and the memory port of
// memory_arbiter.
//
// Signal names keep the arbiter's point of view: i_* are driven into the arbiter and o_* are
// driven by it.
//   master - arbiter side: receives the i_* signals and drives the o_* signals.
//   slave  - environment side (requesters + memory): drives the i_* signals and receives the
//            o_* signals.
interface memory_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    // Instruction-fetch port
    logic            i_Fetch_Req;
    logic [XLEN-1:0] i_Fetch_Addr;
    logic            o_Fetch_Done;
    logic [XLEN-1:0] o_Fetch_Data;

    // Load/store port
    logic            i_Data_Req;
    logic [XLEN-1:0] i_Data_Addr;
    logic            i_Data_Write_Enable;
    logic [XLEN-1:0] i_Data_Write_Data;
    logic [3:0]      i_Data_Byte_Enable;
    logic            o_Data_Done;
    logic [XLEN-1:0] o_Data_Read_Data;

    // Single-port memory
    logic            o_Mem_Req;
    logic [XLEN-1:0] o_Mem_Addr;
    logic [XLEN-1:0] o_Mem_Write_Data;
    logic            o_Mem_Write_Enable;
    logic [3:0]      o_Mem_Byte_Enable;
    logic            i_Mem_Ready;
    logic [XLEN-1:0] i_Mem_Read_Data;

    modport master (
        input  i_Fetch_Req, i_Fetch_Addr,
        input  i_Data_Req, i_Data_Addr, i_Data_Write_Enable, i_Data_Write_Data,
        input  i_Data_Byte_Enable,
        input  i_Mem_Ready, i_Mem_Read_Data,
        output o_Fetch_Done, o_Fetch_Data,
        output o_Data_Done, o_Data_Read_Data,
        output o_Mem_Req, o_Mem_Addr, o_Mem_Write_Data, o_Mem_Write_Enable, o_Mem_Byte_Enable
    );

    modport slave (
        output i_Fetch_Req, i_Fetch_Addr,
        output i_Data_Req, i_Data_Addr, i_Data_Write_Enable, i_Data_Write_Data,
        output i_Data_Byte_Enable,
        output i_Mem_Ready, i_Mem_Read_Data,
        input  o_Fetch_Done, o_Fetch_Data,
        input  o_Data_Done, o_Data_Read_Data,
        input  o_Mem_Req, o_Mem_Addr, o_Mem_Write_Data, o_Mem_Write_Enable, o_Mem_Byte_Enable
    );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port memory between an instruction-fetch requester and a
// load/store requester.
//
// Ports:
//   i_Clock - sole clock, rising edge.
//   i_Reset - synchronous, active-high reset.
//   arb     - memory_arbiter_if.master:
//             fetch request/address in, Done pulse and fetched word out;
//             load/store request in, Done pulse and load data out;
//             latched memory request out, ready and read data in.
//
// Arbitration happens only in IDLE.
//   - Data wins a tie unless STARVE_LIMIT consecutive data grants were made while a fetch was
//     waiting.
//   - Every access is followed by at least one IDLE cycle; this is the cycle in which the
//     owner's Done pulses.
//   - A requester that is finished must drop its request during its Done cycle. A request
//     still high in that cycle counts as a new request.
module memory_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic             i_Clock,
    input logic             i_Reset,
    memory_arbiter_if.master arb
);

    localparam logic [2:0] StarveMax = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        StIdle,
        StGrantFetch,
        StGrantData
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      starve_cnt_q, starve_cnt_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wd_q, mem_wd_d;
    logic            fetch_done_q, fetch_done_d;
    logic [XLEN-1:0] fetch_data_q, fetch_data_d;
    logic            data_done_q, data_done_d;
    logic [XLEN-1:0] data_rd_q, data_rd_d;
    logic            fetch_wins;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q      <= StIdle;
            starve_cnt_q <= 3'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'h0;
            mem_addr_q   <= '0;
            mem_wd_q     <= '0;
            fetch_done_q <= 1'b0;
            fetch_data_q <= '0;
            data_done_q  <= 1'b0;
            data_rd_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wd_q     <= mem_wd_d;
            fetch_done_q <= fetch_done_d;
            fetch_data_q <= fetch_data_d;
            data_done_q  <= data_done_d;
            data_rd_q    <= data_rd_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wd_d     = mem_wd_q;
        fetch_done_d = 1'b0;
        fetch_data_d = fetch_data_q;
        data_done_d  = 1'b0;
        data_rd_d    = data_rd_q;
        fetch_wins   = arb.i_Fetch_Req && (!arb.i_Data_Req || (starve_cnt_q == StarveMax));

        unique case (state_q)
            StIdle: begin
                // i_Mem_Ready is deliberately not looked at here: stray ready is ignored.
                if (fetch_wins) begin
                    state_d      = StGrantFetch;
                    mem_req_d    = 1'b1;
                    mem_addr_d   = arb.i_Fetch_Addr;
                    mem_we_d     = 1'b0;
                    mem_be_d     = 4'h0;
                    mem_wd_d     = '0;
                    starve_cnt_d = 3'd0;
                end else if (arb.i_Data_Req) begin
                    state_d    = StGrantData;
                    mem_req_d  = 1'b1;
                    mem_addr_d = arb.i_Data_Addr;
                    mem_we_d   = arb.i_Data_Write_Enable;
                    mem_be_d   = arb.i_Data_Byte_Enable;
                    mem_wd_d   = arb.i_Data_Write_Data;
                    // Only a data grant that overtakes a waiting fetch counts toward starvation.
                    if (arb.i_Fetch_Req && (starve_cnt_q < StarveMax)) begin
                        starve_cnt_d = starve_cnt_q + 3'd1;
                    end
                end
            end
            StGrantFetch: begin
                if (arb.i_Mem_Ready) begin
                    state_d      = StIdle;
                    mem_req_d    = 1'b0;
                    fetch_done_d = 1'b1;
                    fetch_data_d = arb.i_Mem_Read_Data;
                end
            end
            StGrantData: begin
                if (arb.i_Mem_Ready) begin
                    state_d     = StIdle;
                    mem_req_d   = 1'b0;
                    data_done_d = 1'b1;
                    data_rd_d   = arb.i_Mem_Read_Data;
                end
            end
            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign arb.o_Mem_Req          = mem_req_q;
    assign arb.o_Mem_Addr         = mem_addr_q;
    assign arb.o_Mem_Write_Data   = mem_wd_q;
    assign arb.o_Mem_Write_Enable = mem_we_q;
    assign arb.o_Mem_Byte_Enable  = mem_be_q;
    assign arb.o_Fetch_Done       = fetch_done_q;
    assign arb.o_Fetch_Data       = fetch_data_q;
    assign arb.o_Data_Done        = data_done_q;
    assign arb.o_Data_Read_Data   = data_rd_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed vector table for memory_arbiter plus a hand-written starvation
// sequence. Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_memory_arbiter;

    typedef struct packed {
        logic        rst;
        logic        freq;
        logic [31:0] faddr;
        logic        dreq;
        logic [31:0] daddr;
        logic        dwe;
        logic [31:0] dwd;
        logic [3:0]  dbe;
        logic        rdy;
        logic [31:0] rdata;
    } in_t;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic [3:0]  mem_be;
        logic [31:0] mem_addr;
        logic [31:0] mem_wd;
        logic        fetch_done;
        logic [31:0] fetch_data;
        logic        data_done;
        logic [31:0] data_rd;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
        bit   wd_dc;  // write data of a fetch grant is not compared
    } vec_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    vec_t vecs[$];

    memory_arbiter_if #(.XLEN(32)) bus ();

    memory_arbiter #(
        .XLEN        (32),
        .STARVE_LIMIT(4)
    ) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .arb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t fi(logic r, logic fq, logic [31:0] fa, logic dq, logic [31:0] da,
                               logic we, logic [31:0] wd, logic [3:0] be, logic rd,
                               logic [31:0] rdat);
        in_t v;
        v.rst = r; v.freq = fq; v.faddr = fa; v.dreq = dq; v.daddr = da;
        v.dwe = we; v.dwd = wd; v.dbe = be; v.rdy = rd; v.rdata = rdat;
        return v;
    endfunction

    function automatic out_t fo(logic mq, logic mwe, logic [3:0] mbe, logic [31:0] ma,
                                logic [31:0] mwd, logic fd, logic [31:0] fdat, logic dd,
                                logic [31:0] ddat);
        out_t o;
        o.mem_req = mq; o.mem_we = mwe; o.mem_be = mbe; o.mem_addr = ma; o.mem_wd = mwd;
        o.fetch_done = fd; o.fetch_data = fdat; o.data_done = dd; o.data_rd = ddat;
        return o;
    endfunction

    function automatic out_t sample();
        return fo(bus.o_Mem_Req, bus.o_Mem_Write_Enable, bus.o_Mem_Byte_Enable, bus.o_Mem_Addr,
                  bus.o_Mem_Write_Data, bus.o_Fetch_Done, bus.o_Fetch_Data, bus.o_Data_Done,
                  bus.o_Data_Read_Data);
    endfunction

    task automatic drive(input in_t v);
        rst                     = v.rst;
        bus.i_Fetch_Req         = v.freq;
        bus.i_Fetch_Addr        = v.faddr;
        bus.i_Data_Req          = v.dreq;
        bus.i_Data_Addr         = v.daddr;
        bus.i_Data_Write_Enable = v.dwe;
        bus.i_Data_Write_Data   = v.dwd;
        bus.i_Data_Byte_Enable  = v.dbe;
        bus.i_Mem_Ready         = v.rdy;
        bus.i_Mem_Read_Data     = v.rdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        int   grants;
        int   nd;
        int   nf;
        logic prev_req;
        logic [4:0] seq;
        out_t got;
        out_t mask;

        tests = 0;
        fails = 0;

        // Reset, also with a coincident stray ready.
        vecs.push_back('{fi(1,0,0,0,0,0,0,0,0,0), fo(0,0,0,0,0,0,0,0,0), 0});
        vecs.push_back('{fi(1,0,0,0,0,0,0,0,1,32'h1234), fo(0,0,0,0,0,0,0,0,0), 0});
        // Lone fetch at 0x100, ready in the second request cycle; address change ignored.
        vecs.push_back('{fi(0,1,32'h100,0,0,0,0,0,0,0), fo(1,0,0,32'h100,0,0,0,0,0), 1});
        vecs.push_back('{fi(0,1,32'h1FC,0,0,0,0,0,0,0), fo(1,0,0,32'h100,0,0,0,0,0), 1});
        vecs.push_back('{fi(0,1,32'h1FC,0,0,0,0,0,1,32'h00500093),
                         fo(0,0,0,32'h100,0,1,32'h00500093,0,0), 1});
        vecs.push_back('{fi(0,0,0,0,0,0,0,0,0,0), fo(0,0,0,32'h100,0,0,32'h00500093,0,0), 1});
        // Fetch 0x104 and store 0x200 together: store first, then fetch after one IDLE cycle.
        vecs.push_back('{fi(0,1,32'h104,1,32'h200,1,32'hDEADBEEF,4'hF,0,0),
                         fo(1,1,4'hF,32'h200,32'hDEADBEEF,0,32'h00500093,0,0), 0});
        vecs.push_back('{fi(0,1,32'h104,1,32'h200,1,32'hDEADBEEF,4'hF,1,0),
                         fo(0,1,4'hF,32'h200,32'hDEADBEEF,0,32'h00500093,1,0), 0});
        vecs.push_back('{fi(0,1,32'h104,0,0,0,0,0,0,0),
                         fo(1,0,0,32'h104,0,0,32'h00500093,0,0), 1});
        vecs.push_back('{fi(0,1,32'h104,0,0,0,0,0,1,32'hCAFEF00D),
                         fo(0,0,0,32'h104,0,1,32'hCAFEF00D,0,0), 1});
        vecs.push_back('{fi(0,0,0,0,0,0,0,0,0,0), fo(0,0,0,32'h104,0,0,32'hCAFEF00D,0,0), 1});
        // Load at 0x300; address change during the grant ignored.
        vecs.push_back('{fi(0,0,0,1,32'h300,0,32'h11111111,0,0,0),
                         fo(1,0,0,32'h300,32'h11111111,0,32'hCAFEF00D,0,0), 0});
        vecs.push_back('{fi(0,0,0,1,32'h3FC,0,32'h11111111,0,0,0),
                         fo(1,0,0,32'h300,32'h11111111,0,32'hCAFEF00D,0,0), 0});
        vecs.push_back('{fi(0,0,0,1,32'h3FC,0,32'h11111111,0,1,32'hA5A5A5A5),
                         fo(0,0,0,32'h300,32'h11111111,0,32'hCAFEF00D,1,32'hA5A5A5A5), 0});
        vecs.push_back('{fi(0,0,0,0,0,0,0,0,0,0),
                         fo(0,0,0,32'h300,32'h11111111,0,32'hCAFEF00D,0,32'hA5A5A5A5), 0});
        // Stray ready for three idle cycles.
        for (int k = 0; k < 3; k++) begin
            vecs.push_back('{fi(0,0,0,0,0,0,0,0,1,32'hFFFFFFFF),
                             fo(0,0,0,32'h300,32'h11111111,0,32'hCAFEF00D,0,32'hA5A5A5A5), 0});
        end
        // Store granted, then reset coincident with ready: no Done, all outputs cleared.
        vecs.push_back('{fi(0,0,0,1,32'h400,1,32'h55AA55AA,4'h3,0,0),
                         fo(1,1,4'h3,32'h400,32'h55AA55AA,0,32'hCAFEF00D,0,32'hA5A5A5A5), 0});
        vecs.push_back('{fi(1,0,0,1,32'h400,1,32'h55AA55AA,4'h3,1,32'h77777777),
                         fo(0,0,0,0,0,0,0,0,0), 0});
        // Fetch granted on the first edge after reset falls.
        vecs.push_back('{fi(0,1,32'h500,0,0,0,0,0,0,0), fo(1,0,0,32'h500,0,0,0,0,0), 1});
        vecs.push_back('{fi(0,1,32'h500,0,0,0,0,0,1,32'h0BADF00D),
                         fo(0,0,0,32'h500,0,1,32'h0BADF00D,0,0), 1});
        vecs.push_back('{fi(0,0,0,0,0,0,0,0,0,0), fo(0,0,0,32'h500,0,0,32'h0BADF00D,0,0), 1});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].in);
            step();
            got  = sample();
            mask = '1;
            if (vecs[i].wd_dc) mask.mem_wd = '0;
            tests++;
            if ((got & mask) !== (vecs[i].exp & mask)) begin
                fails++;
                $display("FAIL vec%0d: got %h expected %h", i, got & mask, vecs[i].exp & mask);
            end
        end

        // Starvation: fetch held, data re-requested continuously, single-cycle memory.
        drive(fi(0,1,32'h600,1,32'h700,0,0,0,1,0));
        grants   = 0;
        nd       = 0;
        nf       = 0;
        seq      = '0;
        prev_req = 1'b0;
        for (int cyc = 0; cyc < 40 && grants < 5; cyc++) begin
            step();
            if (bus.o_Data_Done) nd++;
            if (bus.o_Fetch_Done) nf++;
            if (bus.o_Mem_Req && !prev_req) begin
                seq[grants] = (bus.o_Mem_Addr == 32'h600);
                if (bus.o_Mem_Addr == 32'h600) begin
                    check("starve_cnt_cleared", 64'(dut.starve_cnt_q), 64'd0);
                end
                grants++;
            end
            prev_req = bus.o_Mem_Req;
        end
        check("starve_grant_order", 64'(seq), 64'b10000);
        check("starve_data_dones", 64'(nd), 64'd4);
        check("starve_no_early_fetch_done", 64'(nf), 64'd0);
        step();
        check("starve_fetch_done", 64'(bus.o_Fetch_Done), 64'd1);
        drive(fi(0,0,0,0,0,0,0,0,0,0));
        step();
        check("starve_idle_after", 64'({bus.o_Mem_Req, bus.o_Fetch_Done, bus.o_Data_Done}),
              64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter XLEN, default 32: data and address width.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive data grants after which a pending fetch wins.
REQ-003 i_Clock  in  1: sole clock; all state changes on its rising edge.
REQ-004 i_Reset  in  1: synchronous, active-high reset.
REQ-005 i_Fetch_Req  in  1: instruction-fetch read request; held high until o_Fetch_Done.
REQ-006 i_Fetch_Addr  in  XLEN: fetch address.
REQ-007 o_Fetch_Done  out  1: one-cycle pulse, fetch complete.
REQ-008 o_Fetch_Data  out  XLEN: fetched word; valid while o_Fetch_Done is high.
REQ-009 i_Data_Req  in  1: load/store request; held high until o_Data_Done.
REQ-010 i_Data_Addr  in  XLEN: load/store address.
REQ-011 i_Data_Write_Enable  in  1: 1 = store, 0 = load.
REQ-012 i_Data_Write_Data  in  XLEN: store data.
REQ-013 i_Data_Byte_Enable  in  4: store byte lanes.
REQ-014 o_Data_Done  out  1: one-cycle pulse, load/store complete.
REQ-015 o_Data_Read_Data  out  XLEN: load result; valid while o_Data_Done is high.
REQ-016 o_Mem_Req  out  1: request to the single-port memory.
REQ-017 o_Mem_Addr, o_Mem_Write_Data  out  XLEN each: latched request address and data.
REQ-018 o_Mem_Write_Enable  out  1; o_Mem_Byte_Enable  out  4: latched write controls.
REQ-019 i_Mem_Ready  in  1: memory accepted and completed the current access, 1..N cycles after o_Mem_Req.
REQ-020 i_Mem_Read_Data  in  XLEN: read data; valid while i_Mem_Ready is high.

Function
REQ-021 States: IDLE, GRANT_FETCH, GRANT_DATA.
REQ-022 IDLE with no request: stay in IDLE; o_Mem_Req = 0.
REQ-023 IDLE with a request:
- Data only: go to GRANT_DATA.
- Fetch only: go to GRANT_FETCH.
- Both: data wins, unless the starvation counter equals STARVE_LIMIT, in which case fetch wins.
REQ-024 On the grant edge, register the winner's address, write enable, write data and byte enable into the o_Mem_* outputs; set o_Mem_Req = 1 from the next cycle.
- Fetch grants drive write enable = 0 and byte enable = 0.
REQ-025 In a GRANT state, o_Mem_Req and the o_Mem_* fields stay constant until the cycle in which i_Mem_Ready = 1.
- Requester input changes during this time are ignored.
REQ-026 On the cycle i_Mem_Ready = 1:
- Next cycle: o_Mem_Req = 0, the state returns to IDLE, and the owner's Done pulses for exactly one cycle with i_Mem_Read_Data registered into its data output.
- Stores also pulse o_Data_Done; o_Data_Read_Data is then don't-care.
REQ-027 Minimum turnaround: one IDLE cycle between consecutive grants, so o_Mem_Req deasserts for at least one cycle between accesses.
REQ-028 Starvation counter, 3 bits:
- Increments on each data grant made while i_Fetch_Req is high, saturating at STARVE_LIMIT.
- Clears to 0 on every fetch grant.
REQ-029 A Done pulse goes only to the granted requester; the non-granted Done stays 0.
REQ-030 Data output registers hold their last value when Done is low.
REQ-031 i_Mem_Ready while in IDLE is ignored: no Done pulse and no state change.
REQ-032 The same requester re-requesting in the cycle after its Done is treated as a new request and arbitrated normally.

Reset
REQ-033 While i_Reset is high at a clock edge, the block goes to:
- state IDLE; starvation counter = 0;
- o_Mem_Req, o_Mem_Write_Enable, o_Fetch_Done, o_Data_Done = 0;
- o_Mem_Byte_Enable = 4'h0;
- o_Mem_Addr, o_Mem_Write_Data, o_Fetch_Data, o_Data_Read_Data = 0.
REQ-034 Reset in mid-transaction abandons the access.
- o_Mem_Req is 0 the cycle after the reset edge.
- No Done pulse is issued for the abandoned access, even if i_Mem_Ready coincides with reset.
REQ-035 The first grant is possible on the first edge after i_Reset falls.

Verification
REQ-036 Lone fetch:
- Stimulus: i_Fetch_Req = 1, i_Fetch_Addr = 0x100; memory returns 0x00500093 with i_Mem_Ready 2 cycles after o_Mem_Req.
- Response: o_Mem_Addr = 0x100, o_Mem_Write_Enable = 0; o_Fetch_Done pulses once with o_Fetch_Data = 0x00500093; o_Data_Done stays 0.
REQ-037 Simultaneous requests:
- Stimulus: fetch at 0x104 and store at 0x200 (data 0xDEADBEEF, byte enable 4'hF) both raised in IDLE; single-cycle memory.
- Response: data granted first (o_Mem_Write_Enable = 1, o_Mem_Addr = 0x200), o_Data_Done pulses; one IDLE cycle follows, then the fetch is granted and o_Fetch_Done pulses.
REQ-038 Starvation:
- Stimulus: i_Fetch_Req held high and i_Data_Req re-raised immediately after each o_Data_Done; STARVE_LIMIT = 4.
- Response: exactly 4 data grants, then a fetch grant, with the counter back to 0 after the fetch grant.
REQ-039 Reset mid-access:
- Stimulus: i_Reset asserted while in GRANT_DATA, coincident with i_Mem_Ready = 1.
- Response: the next cycle shows o_Mem_Req = 0, o_Data_Done = 0 and all outputs at their reset values; a new fetch after reset completes normally.
REQ-040 Stray ready:
- Stimulus: i_Mem_Ready = 1 for 3 cycles with no requests pending.
- Response: the block stays in IDLE; no Done pulses; o_Mem_Req = 0.
